// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling stage.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Ceiling log2 usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/maxpool_stream_if.sv
// Pixel-in / pooled-value-out bus with frame control for maxpool_stream.
interface maxpool_stream_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                         start;
  logic                         avg_mode;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         finish;

  // master: the environment feeding pixels and consuming results
  modport master (
    output start, avg_mode, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, finish
  );

  // slave: the pooling block
  modport slave (
    input  start, avg_mode, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, finish
  );
endinterface

// File: rtl/pool_combine.sv
// Pairwise combine for pooling: signed max or sum, at accumulator width.
module pool_combine
  import pool_pkg::*;
#(
  parameter int unsigned ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  input  logic                    mode,
  output logic signed [ACC_W-1:0] y_c
);

  always_comb begin
    if (mode == MODE_AVG) y_c = a + b;
    else                  y_c = (a > b) ? a : b;
  end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming max/average pooling over channel-major frames using one
// line buffer of partial window results instead of a frame store.
module maxpool_stream
  import pool_pkg::*;
#(
  parameter int unsigned IMG_SIZE   = 24,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned POOL_SIZE  = 2,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  maxpool_stream_if.slave bus
);

  localparam int unsigned OUT_SIZE = IMG_SIZE / POOL_SIZE;
  localparam int unsigned SPAN     = OUT_SIZE * POOL_SIZE;
  localparam int unsigned LOG_P    = clog2(POOL_SIZE);
  localparam int unsigned SHIFT    = 2 * LOG_P;
  localparam int unsigned ACC_W    = DATA_WIDTH + SHIFT;
  localparam int unsigned CH_W     = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
  localparam int unsigned POS_W    = clog2(IMG_SIZE + 1);
  localparam int unsigned WIN_W    = clog2(OUT_SIZE + 1);
  localparam int unsigned LB_W     = (OUT_SIZE > 1) ? clog2(OUT_SIZE) : 1;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(IMG_SIZE - 1);
  localparam logic [POS_W-1:0] POS_SPAN = POS_W'(SPAN);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [LOG_P-1:0] SUB_LAST = LOG_P'(POOL_SIZE - 1);

  state_t state_q, state_d;

  logic                         mode_q;
  logic [CH_W-1:0]              ch_q;
  logic [POS_W-1:0]             row_q, col_q;
  logic [LOG_P-1:0]             sub_row_q, sub_col_q;
  logic [WIN_W-1:0]             win_q;
  logic signed [ACC_W-1:0]      h_acc_q;
  logic signed [ACC_W-1:0]      lb_q [OUT_SIZE];
  logic                         out_valid_q;
  logic signed [DATA_WIDTH-1:0] data_out_q;
  logic                         finish_q;

  logic                         rdy, go, fin_d, accept, frame_last;
  logic                         col_end, in_span, lb_wr, complete;
  logic [LB_W-1:0]              lb_idx;
  logic signed [ACC_W-1:0]      pix_ext, h_comb, h_val, lb_rd, v_comb, v_val;
  logic signed [DATA_WIDTH-1:0] res;

  assign frame_last = (ch_q == CH_LAST) && (row_q == POS_LAST) && (col_q == POS_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    go      = 1'b0;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          go      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        rdy = !out_valid_q || bus.out_ready;
        if (bus.in_valid && rdy && frame_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid_q || bus.out_ready) begin
          fin_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == RUN) && bus.in_valid && rdy;

  pool_combine #(.ACC_W(ACC_W)) u_hcomb (
    .a(h_acc_q), .b(pix_ext), .mode(mode_q), .y_c(h_comb)
  );

  pool_combine #(.ACC_W(ACC_W)) u_vcomb (
    .a(lb_rd), .b(h_val), .mode(mode_q), .y_c(v_comb)
  );

  // Window datapath: horizontal run, then vertical fold through the line buffer.
  always_comb begin
    pix_ext  = {{SHIFT{bus.data_in[DATA_WIDTH-1]}}, bus.data_in};
    h_val    = (sub_col_q == '0) ? pix_ext : h_comb;
    lb_idx   = LB_W'(win_q);
    lb_rd    = lb_q[lb_idx];
    v_val    = (sub_row_q == '0) ? h_val : v_comb;
    col_end  = (sub_col_q == SUB_LAST);
    in_span  = (col_q < POS_SPAN) && (row_q < POS_SPAN);
    lb_wr    = accept && col_end && in_span;
    complete = lb_wr && (sub_row_q == SUB_LAST);
    if (mode_q == MODE_AVG) res = DATA_WIDTH'(v_val >>> SHIFT);
    else                    res = DATA_WIDTH'(v_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_MAX;
      ch_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      sub_row_q <= '0;
      sub_col_q <= '0;
      win_q     <= '0;
      h_acc_q   <= '0;
    end else if (go) begin
      mode_q    <= bus.avg_mode;
      ch_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      sub_row_q <= '0;
      sub_col_q <= '0;
      win_q     <= '0;
      h_acc_q   <= '0;
    end else if (accept) begin
      h_acc_q <= h_val;
      if (col_q == POS_LAST) begin
        col_q     <= '0;
        sub_col_q <= '0;
        win_q     <= '0;
        if (row_q == POS_LAST) begin
          row_q     <= '0;
          sub_row_q <= '0;
          ch_q      <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end else begin
          row_q     <= row_q + 1'b1;
          sub_row_q <= sub_row_q + 1'b1;
        end
      end else begin
        col_q     <= col_q + 1'b1;
        sub_col_q <= sub_col_q + 1'b1;
        if (col_end) win_q <= win_q + 1'b1;
      end
    end
  end

  // Partial sums need no reset: row 0 of every window band overwrites its entry.
  always_ff @(posedge clk) begin
    if (lb_wr) lb_q[lb_idx] <= v_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      finish_q <= fin_d;
      if (complete) begin
        out_valid_q <= 1'b1;
        data_out_q  <= res;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream across three geometries
// (24x24x2 P2, 5x5x3 P2, 8x8x2 P4).
module tb_maxpool_stream;

  localparam int unsigned DW = 16;

  function automatic int unsigned cfg_img(input int s);
    case (s)
      0:       return 24;
      1:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned cfg_ch(input int s);
    case (s)
      0:       return 2;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned cfg_p(input int s);
    case (s)
      0:       return 2;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 start_s    [3];
  logic                 avg_s      [3];
  logic                 in_valid_s [3];
  logic                 out_ready_s[3];
  logic signed [DW-1:0] data_in_s  [3];
  logic                 in_ready_o [3];
  logic                 out_valid_o[3];
  logic                 finish_o   [3];
  logic signed [DW-1:0] data_out_o [3];

  maxpool_stream_if #(.DATA_WIDTH(DW)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].start     = start_s[g];
    assign bus[g].avg_mode  = avg_s[g];
    assign bus[g].in_valid  = in_valid_s[g];
    assign bus[g].data_in   = data_in_s[g];
    assign bus[g].out_ready = out_ready_s[g];
    assign in_ready_o[g]    = bus[g].in_ready;
    assign out_valid_o[g]   = bus[g].out_valid;
    assign data_out_o[g]    = bus[g].data_out;
    assign finish_o[g]      = bus[g].finish;

    maxpool_stream #(
      .IMG_SIZE(cfg_img(g)), .CHANNELS(cfg_ch(g)),
      .POOL_SIZE(cfg_p(g)), .DATA_WIDTH(DW)
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus[g])
    );
  end

  int n_checks;
  int n_errors;
  int exp_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus patterns: 0 ramp, 1 avg floor windows, 2 random, 3 one hot max per P4 window, 4 all min.
  function automatic int gen_pix(input int pat, input int sel, input int c, input int r, input int x);
    int n, p, k;
    n = int'(cfg_img(sel));
    p = int'(cfg_p(sel));
    case (pat)
      0: return c * n * n + r * n + x;
      1: begin
        k = (r % 2) * 2 + (x % 2);
        if (((r / 2) + (x / 2)) % 2 == 0) begin
          case (k)
            0: return -3;
            1: return -2;
            2: return 5;
            default: return 1;
          endcase
        end else begin
          return (k == 3) ? -2 : -1;
        end
      end
      2: return int'($urandom_range(0, 65535)) - 32768;
      3: return (((r % p) * p + (x % p)) == (((r / p) * 3 + (x / p) * 5 + c) % (p * p))) ? 32767 : -32768;
      default: return -32768;
    endcase
  endfunction

  task automatic run_frame(input int sel, input bit avg, input int pat, input bit bp, input int abort_at);
    int n, nc, p, os, sh, total, idx, cyc, budget, last_cyc, n_out;
    int cc, rr, xx, v, m;
    longint s;
    bit mv, mv_next, fin_exp, fin_next, draining, done, orr;
    int frame[];

    n = int'(cfg_img(sel));
    nc = int'(cfg_ch(sel));
    p = int'(cfg_p(sel));
    os = n / p;
    sh = 2 * $clog2(p);
    total = nc * n * n;
    frame = new[total];
    for (int c = 0; c < nc; c++)
      for (int r = 0; r < n; r++)
        for (int x = 0; x < n; x++)
          frame[(c * n + r) * n + x] = gen_pix(pat, sel, c, r, x);
    exp_q.delete();

    @(negedge clk);
    start_s[sel] = 1'b1;
    avg_s[sel] = avg;
    @(negedge clk);
    start_s[sel] = 1'b0;

    idx = 0; cyc = 0; last_cyc = -1; n_out = 0;
    mv = 1'b0; fin_exp = 1'b0; draining = 1'b0; done = 1'b0;
    budget = total * 4 + 100;
    while (!done && cyc < budget) begin
      if (abort_at > 0 && idx == abort_at) begin
        in_valid_s[sel] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_out_valid", out_valid_o[sel], 0);
        check("abort_in_ready", in_ready_o[sel], 0);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #1;
          check("abort_finish", finish_o[sel], 0);
        end
        exp_q.delete();
        return;
      end
      orr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_s[sel] = orr;
      in_valid_s[sel] = (idx < total);
      data_in_s[sel] = (idx < total) ? DW'(frame[idx]) : '0;
      // A start pulse mid-frame, with the mode flipped, must be ignored.
      start_s[sel] = (cyc == 12);
      avg_s[sel] = (cyc == 12) ? !avg : avg;
      #1;
      check("out_valid", out_valid_o[sel], mv);
      check("in_ready", in_ready_o[sel], !draining && (!mv || orr));
      check("finish", finish_o[sel], fin_exp);
      if (mv) begin
        if (exp_q.size() == 0) check("queue_underflow", 1, 0);
        else begin
          check("data_out", data_out_o[sel], exp_q[0]);
          if (orr) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end

      fin_next = 1'b0;
      mv_next = mv;
      if (fin_exp) begin
        done = 1'b1;
        if (!bp) check("finish_latency", cyc - last_cyc, 2);
      end else if (draining) begin
        if (!mv || orr) begin
          fin_next = 1'b1;
          mv_next = 1'b0;
        end
      end else if (!mv || orr) begin
        cc = idx / (n * n);
        rr = (idx / n) % n;
        xx = idx % n;
        mv_next = 1'b0;
        if (rr % p == p - 1 && xx % p == p - 1 && rr < os * p && xx < os * p) begin
          s = 0;
          m = frame[(cc * n + rr - p + 1) * n + xx - p + 1];
          for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++) begin
              v = frame[(cc * n + rr - p + 1 + i) * n + xx - p + 1 + j];
              s += v;
              if (v > m) m = v;
            end
          exp_q.push_back(avg ? int'(s >>> sh) : m);
          mv_next = 1'b1;
        end
        idx++;
        if (idx == total) begin
          draining = 1'b1;
          last_cyc = cyc;
        end
      end
      mv = mv_next;
      fin_exp = fin_next;
      cyc++;
      @(negedge clk);
    end
    start_s[sel] = 1'b0;
    in_valid_s[sel] = 1'b0;
    check("frame_done", done, 1);
    check("output_count", n_out, nc * os * os);
    check("queue_left", exp_q.size(), 0);
    #1;
    check("finish_one_cycle", finish_o[sel], 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      avg_s[i] = 1'b0;
      in_valid_s[i] = 1'b0;
      out_ready_s[i] = 1'b0;
      data_in_s[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", in_ready_o[i], 0);
      check("rst_out_valid", out_valid_o[i], 0);
      check("rst_data_out", data_out_o[i], 0);
      check("rst_finish", finish_o[i], 0);
    end
    reset = 1'b0;

    run_frame(0, 1'b0, 0, 1'b0, 0);
    run_frame(0, 1'b1, 1, 1'b0, 0);
    run_frame(0, 1'b0, 2, 1'b1, 0);
    run_frame(0, 1'b1, 2, 1'b1, 0);
    run_frame(1, 1'b0, 0, 1'b0, 0);
    run_frame(1, 1'b1, 2, 1'b1, 0);
    run_frame(2, 1'b0, 3, 1'b0, 0);
    run_frame(2, 1'b1, 4, 1'b0, 0);
    run_frame(0, 1'b0, 0, 1'b0, 100);
    run_frame(0, 1'b1, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
